// File: rtl/rmii_tx_driver_pkg.sv
// Shared constants, FSM state type and helper functions for the RMII transmit driver.
// Optional FCS support is selected with the RMII_TX_FCS_EN macro.
package rmii_tx_driver_pkg;

  localparam int unsigned RMII_PREAMBLE_DIBITS = 32;
  localparam logic [31:0] RMII_CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] RMII_CRC32_INIT      = 32'hFFFFFFFF;
  localparam int unsigned FCS_DIBITS           = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
`ifdef RMII_TX_FCS_EN
    ST_FCS,
`endif
    ST_IFG
  } state_e;

  // Ceiling log2, minimum result 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc32_dibit_step(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ RMII_CRC32_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/rmii_tx_driver_crc32_dibit.sv
// CRC-32 accumulator advancing two bits per enabled cycle.
// Ports: clk_i, rst_i (sync, active high), init_i (reload init value),
//        en_i (absorb in_i), in_i[1:0] dibit, crc_o[31:0] running remainder.
module crc32_dibit
  import rmii_tx_driver_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [1:0]  in_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // init has priority so a new frame always starts from a clean remainder
  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = RMII_CRC32_INIT;
    else if (en_i) crc_d = crc32_dibit_step(crc_q, in_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= RMII_CRC32_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rmii_tx_driver.sv
// RMII transmit driver: prepends preamble/SFD to a dibit stream, drives TX_EN/TXD,
// optionally appends the FCS (macro RMII_TX_FCS_EN) and enforces the inter-frame gap.
// Ports: clk_i, rst_i (sync, active high); in_i/in_valid_i/in_last_i/in_ready_o payload
//        stream; txen_o/txd_o registered RMII pins; busy_o (not IDLE); underrun_o abort pulse.
module rmii_tx_driver
  import rmii_tx_driver_pkg::*;
#(
  parameter int unsigned IFG_LEN = 48
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] in_i,
  input  logic       in_valid_i,
  input  logic       in_last_i,
  output logic       in_ready_o,
  output logic       txen_o,
  output logic [1:0] txd_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int unsigned    CNT_W    = clog2(max_u(IFG_LEN, RMII_PREAMBLE_DIBITS));
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(RMII_PREAMBLE_DIBITS - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             txen_q, txen_d;
  logic [1:0]       txd_q, txd_d;
  logic             underrun_q, underrun_d;

`ifdef RMII_TX_FCS_EN
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_DIBITS - 1);

  logic [31:0] crc;
  logic [31:0] fcs;
  logic        crc_init;
  logic        xfer;

  assign xfer     = (state_q == ST_DATA) && in_valid_i;
  assign crc_init = (state_q == ST_IDLE) && in_valid_i;
  assign fcs      = ~crc;

  crc32_dibit u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (crc_init),
    .en_i   (xfer),
    .in_i   (in_i),
    .crc_o  (crc)
  );
`endif

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      txen_q     <= 1'b0;
      txd_q      <= 2'b00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txen_q     <= txen_d;
      txd_q      <= txd_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state logic; the gap is only counted once txen has actually dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (in_valid_i) state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (cnt_q == PRE_LAST) state_d = ST_DATA;
      ST_DATA: begin
        if (!in_valid_i) state_d = ST_IFG;
`ifdef RMII_TX_FCS_EN
        else if (in_last_i) state_d = ST_FCS;
`else
        else if (in_last_i) state_d = ST_IFG;
`endif
      end
`ifdef RMII_TX_FCS_EN
      ST_FCS:      if (cnt_q == FCS_LAST) state_d = ST_IFG;
`endif
      ST_IFG:      if (!txen_q && (cnt_q == IFG_LAST)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output / counter next values
  always_comb begin
    cnt_d      = cnt_q;
    txen_d     = txen_q;
    txd_d      = txd_q;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          txen_d = 1'b1;
          txd_d  = 2'b01;
          cnt_d  = CNT_W'(1);
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          txd_d = 2'b11;
          cnt_d = '0;
        end else begin
          txd_d = 2'b01;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        cnt_d = '0;
        if (in_valid_i) begin
          txen_d = 1'b1;
          txd_d  = in_i;
        end else begin
          txen_d     = 1'b0;
          txd_d      = 2'b00;
          underrun_d = 1'b1;
        end
      end
`ifdef RMII_TX_FCS_EN
      ST_FCS: begin
        txd_d = fcs[{cnt_q[3:0], 1'b0} +: 2];
        cnt_d = (cnt_q == FCS_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
`endif
      ST_IFG: begin
        // A normal frame end arrives here with txen still high
        if (txen_q) begin
          txen_d = 1'b0;
          txd_d  = 2'b00;
          cnt_d  = '0;
        end else begin
          cnt_d = (cnt_q == IFG_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign in_ready_o = (state_q == ST_DATA);
  assign busy_o     = (state_q != ST_IDLE);
  assign txen_o     = txen_q;
  assign txd_o      = txd_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_rmii_tx_driver.sv
// Directed bench for rmii_tx_driver: table-driven short frame plus multi-cycle sequences.
module tb_rmii_tx_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_d;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       txen;
  logic [1:0] txd;
  logic       busy;
  logic       underrun;

  int n_chk  = 0;
  int n_pass = 0;

  always #10 clk = ~clk;

  rmii_tx_driver #(.IFG_LEN(48)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_i       (in_d),
    .in_valid_i (in_valid),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .txen_o     (txen),
    .txd_o      (txd),
    .busy_o     (busy),
    .underrun_o (underrun)
  );

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       l;
    logic [5:0] exp;  // {txen, txd, in_ready, busy, underrun}
  } vec_t;

`ifdef RMII_TX_FCS_EN
  localparam int B2B_HIGH = 32 + 256 + 16;
`else
  localparam int B2B_HIGH = 32 + 256;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_d = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expects IDLE with in_valid already high; walks the full 32-dibit preamble
  task automatic check_preamble(input string tag);
    logic bad;
    step();
    chk({tag, "_rise"}, {29'd0, txen, txd}, {29'd0, 1'b1, 2'b01});
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (txen !== 1'b1 || txd !== 2'b01 || in_ready !== 1'b0) bad = 1'b1;
    end
    chk({tag, "_pre01"}, {31'd0, bad}, 32'd0);
    step();
    chk({tag, "_sfd"}, {29'd0, txen, txd, in_ready}, {28'd0, 1'b1, 2'b11, 1'b1});
  endtask

  initial begin
    vec_t       vt [41];
    logic [1:0] pd [8];
    logic       bad;
    logic       bad2;
    int         n;
    int         pulses;

    // Frame 0x12 0x34: dibits LSB-first
    pd = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 31; i++) vt[i] = '{1'b1, 2'b10, 1'b0, {1'b1, 2'b01, 1'b0, 1'b1, 1'b0}};
    vt[31] = '{1'b1, 2'b10, 1'b0, {1'b1, 2'b11, 1'b1, 1'b1, 1'b0}};
    for (int k = 0; k < 8; k++)
      vt[32+k] = '{1'b1, pd[k], 1'(k == 7), {1'b1, pd[k], 1'(k != 7), 1'b1, 1'b0}};
    vt[40] = '{1'b0, 2'b00, 1'b0, {1'b0, 2'b00, 1'b0, 1'b1, 1'b0}};

    // Reset held with in_valid high
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_d = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_hold%0d", i), {27'd0, txen, txd, in_ready, busy, underrun}, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("rst_release_start", {29'd0, txen, txd, busy}, {28'd0, 1'b1, 2'b01, 1'b1});

`ifndef RMII_TX_FCS_EN
    // Table-driven short frame
    do_reset();
    for (int i = 0; i < 41; i++) begin
      in_valid = vt[i].v; in_d = vt[i].d; in_last = vt[i].l;
      step();
      chk($sformatf("vec%0d", i), {26'd0, txen, txd, in_ready, busy, underrun}, {26'd0, vt[i].exp});
    end
    // Gap: in_valid high is ignored for 48 cycles, then the next frame starts
    in_valid = 1'b1; in_last = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (txen !== 1'b0 || in_ready !== 1'b0 || txd !== 2'b00) bad = 1'b1;
    end
    chk("ifg_low", {31'd0, bad}, 32'd0);
    step();
    chk("ifg_rise", {31'd0, txen}, 32'd1);
`else
    // "123456789" followed by FCS 26 39 F4 CB
    begin
      logic [7:0]  by;
      logic [31:0] fcs_exp;
      fcs_exp = 32'hCBF43926;
      do_reset();
      in_valid = 1'b1; in_d = 2'b01;
      check_preamble("fcs");
      bad = 1'b0;
      for (int b = 0; b < 9; b++) begin
        by = 8'h31 + 8'(b);
        for (int j = 0; j < 4; j++) begin
          in_d = by[2*j +: 2];
          in_last = (b == 8 && j == 3);
          step();
          if (txd !== in_d || txen !== 1'b1) bad = 1'b1;
        end
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("fcs_payload", {31'd0, bad}, 32'd0);
      bad2 = 1'b0;
      for (int j = 0; j < 16; j++) begin
        step();
        if (txd !== fcs_exp[2*j +: 2] || txen !== 1'b1) begin
          bad2 = 1'b1;
          $display("FAIL fcs_dibit%0d: got %0h, expected %0h", j, txd, fcs_exp[2*j +: 2]);
        end
      end
      n_chk++;
      if (!bad2) n_pass++;
      step();
      chk("fcs_fall", {31'd0, txen}, 32'd0);
    end
`endif

    // Underrun after 5 payload dibits
    do_reset();
    in_valid = 1'b1; in_d = 2'b01;
    check_preamble("ur");
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_d = 2'(i);
      step();
      if (txd !== 2'(i) || txen !== 1'b1) bad = 1'b1;
    end
    chk("ur_payload", {31'd0, bad}, 32'd0);
    in_valid = 1'b0;
    step();
    chk("ur_edge", {29'd0, txen, underrun, busy}, {29'd0, 1'b0, 1'b1, 1'b1});
    n = 1; pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (underrun === 1'b1) pulses++;
      if (busy === 1'b1) n++;
      else break;
    end
    chk("ur_busy_len", 32'(n), 32'd48);
    chk("ur_single_pulse", 32'(pulses), 32'd0);
    chk("ur_idle", {30'd0, busy, txen}, 32'd0);

    // Back-to-back 64-byte frames with in_valid held high
    begin
      int  rise1, fall1, rise2, cyc, k;
      logic prev, acc, gap_bad, data_bad;
      logic [1:0] exp_d;
      do_reset();
      in_valid = 1'b1; in_d = 2'b00; in_last = 1'b0;
      rise1 = -1; fall1 = -1; rise2 = -1; cyc = 0; k = 0;
      prev = 1'b0; gap_bad = 1'b0; data_bad = 1'b0; exp_d = 2'b00;
      for (int c = 0; c < 2000 && rise2 < 0; c++) begin
        acc = in_ready;
        if (acc) begin
          exp_d = 2'(k % 4);
          in_d = exp_d;
          in_last = ((k % 256) == 255);
        end else begin
          in_last = 1'b0;
        end
        step();
        cyc++;
        if (acc) begin
          if (txd !== exp_d) data_bad = 1'b1;
          k++;
        end
        if (txen === 1'b1 && !prev) begin
          if (rise1 < 0) rise1 = cyc;
          else if (fall1 >= 0) rise2 = cyc;
        end
        if (txen === 1'b0 && prev && fall1 < 0) fall1 = cyc;
        if (fall1 >= 0 && rise2 < 0 && in_ready !== 1'b0) gap_bad = 1'b1;
        prev = txen;
      end
      chk("b2b_high_len", 32'(fall1 - rise1), 32'(B2B_HIGH));
      chk("b2b_gap", 32'(rise2 - fall1), 32'd49);
      chk("b2b_ready_gap", {31'd0, gap_bad}, 32'd0);
      chk("b2b_data", {31'd0, data_bad}, 32'd0);
    end

    // Reset at preamble cycle 10
    do_reset();
    in_valid = 1'b1; in_d = 2'b01;
    step();
    for (int i = 0; i < 9; i++) step();
    chk("mp_before", {29'd0, txen, busy, in_ready}, {29'd0, 1'b1, 1'b1, 1'b0});
    rst = 1'b1;
    step();
    chk("mp_rst_edge", {28'd0, txen, txd, underrun, busy}, 32'd0);
    rst = 1'b0;
    check_preamble("mp_after");

    // Reset in the middle of DATA
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_d = 2'(i + 1);
      step();
      if (txd !== 2'(i + 1)) bad = 1'b1;
    end
    chk("md_payload", {31'd0, bad}, 32'd0);
    rst = 1'b1;
    step();
    chk("md_rst_edge", {27'd0, txen, txd, underrun, busy, in_ready}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (underrun !== 1'b0 || txen !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("md_quiet", {31'd0, bad}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rmii_tx_driver.md
# rmii_tx_driver

Transmits Ethernet frames over the RMII interface towards the PHY, the transmit-side counterpart of the RMII receive driver. It accepts a frame as a stream of dibits over a valid/ready handshake and generates the 7-byte preamble and the SFD. It drives TX_EN/TXD[1:0] synchronously to the 50 MHz REF_CLK, optionally appends the FCS, and enforces the inter-frame gap before the next frame. PHY reset and strap configuration stay in the receive driver; this block only drives the transmit pins.

## Interface
- IFG_LEN, default 48: inter-frame gap in clk cycles (dibits); 48 = 96 bit times.
- clk  in  1  50 MHz RMII REF_CLK; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in  in  2  payload dibit, LSB-first order: byte bits [1:0] first, [7:6] last.
- in_valid  in  1  `in` holds a valid dibit.
- in_last  in  1  qualifies the final payload dibit of the frame; sampled only on an accepted transfer.
- in_ready  out  1  block accepts `in` this cycle; transfer = in_valid && in_ready.
- txen  out  1  RMII TX_EN, registered.
- txd  out  2  RMII TXD[1:0], registered.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- The FSM has these states: IDLE, PREAMBLE, DATA, FCS (only with the macro), IFG.
- Reset values: state IDLE, txen 0, txd 2'b00, in_ready 0, busy 0, underrun 0, all counters 0.
- IDLE: if in_valid is high at an edge, go to PREAMBLE. On that edge txen<=1, txd<=2'b01, cnt<=1. The first dibit is not consumed.
- PREAMBLE: txd is 2'b01 for 31 cycles in total, then 2'b11 (SFD tail) for 1 cycle. That is 32 dibits = 0x55×7 + 0xD5. Go to DATA on the edge that loads 2'b11.
- in_ready = (state == DATA), combinational from the state register.
- DATA, on each edge:
  - If in_valid: txd<=in, txen<=1.
  - If the transfer also has in_last: go to FCS (macro on) or IFG (macro off).
  - If !in_valid: abort. txen<=0, txd<=00, underrun<=1 for one cycle, go to IFG. No FCS is sent.
- IFG: txen=0, txd=00 for IFG_LEN cycles, counted from the first cycle txen is low. Then go to IDLE.
- in_valid during IFG is ignored; the data is held by the upstream source.
- No minimum-size padding. The source supplies frames of at least 60 bytes (64 with FCS appended externally).
- rst asserted mid-frame: outputs take their reset values on that edge. No IFG is applied and no underrun pulse is generated.

## Timing
- Sample of in_valid in IDLE to txen rising: 1 cycle.
- txen rising to first payload dibit on txd: 32 cycles.
- Accepted dibit to txd: 1 cycle (registered).
- Last payload dibit to txen falling:
  - Macro off: next edge.
  - Macro on: after 16 FCS dibits.
- txen falling to the next possible txen rising: IFG_LEN + 1 cycles minimum (IFG_LEN gap cycles + 1 IDLE sample).
- Throughput: 1 dibit/cycle in DATA, with no bubbles permitted.

## Configuration
- RMII_TX_FCS_EN defined: CRC-32 is accumulated over every accepted payload dibit.
  - CRC parameters: reflected poly 32'hEDB88320, init 32'hFFFFFFFF.
  - In FCS state, ~crc is emitted LSB-first as 16 dibits, then the block goes to IFG.
  - The CRC is reinitialised on entry to PREAMBLE.
- Undefined: no CRC logic and no FCS state. The frame ends after the in_last dibit, and the source must supply the FCS itself.

## Structure
- params.vh (existing shared include, already providing clog2) gains these constants:
  - RMII_PREAMBLE_DIBITS = 32
  - RMII_CRC32_POLY = 32'hEDB88320
  - RMII_CRC32_INIT = 32'hFFFFFFFF
- Counter widths use clog2(max(IFG_LEN, RMII_PREAMBLE_DIBITS)).
- One sub-module, crc32_dibit, is instantiated only under RMII_TX_FCS_EN:
  - Inputs: clk, rst, init, en, in[1:0].
  - Output: crc[31:0].
  - Advances the CRC by 2 bits per enabled cycle.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> txen=0, txd=00, in_ready=0, busy=0, underrun=0 throughout. Frame starts on the first cycle after release.
- Frame 0x12 0x34, macro off -> txd shows 31×01, 11, then 10 00 01 00 00 01 11 00. txen falls on the next edge and stays low ≥48 cycles.
- ASCII "123456789", macro on -> payload followed by FCS bytes 26 39 F4 CB (dibits LSB-first). txen is high for 32+36+16 cycles.
- Underrun: drop in_valid after 5 payload dibits -> txen falls on the next edge, underrun is high exactly 1 cycle, busy stays high 48 cycles, then IDLE.
- Back-to-back: in_valid held high across two 64-byte frames -> the second txen rise is exactly 49 cycles after the first txen fall, and in_ready stays low during the gap.
- Reset mid-PREAMBLE (cycle 10) and mid-DATA -> txen=0 on the rst edge, no underrun pulse. The next frame after release carries a full 32-dibit preamble.
